// File: rtl/hdmi_in_capture_v2.sv
// HDMI receive capture: registers RGB/DE/HS/VS, measures frame geometry, locks on stable frames and
// queues whole locked frames; pixel->FIFO write 2 cycles; FWFT valid/ready out, drops counted when full.

module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_vld,
  input  logic [W-1:0] wr_dat,
  output logic         full,
  output logic         rd_vld,
  input  logic         rd_rdy,
  output logic [W-1:0] rd_dat
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_wr, do_rd;

  always_comb begin
    full     = (cnt_q == FULL_CNT);
    rd_vld   = (cnt_q != '0);
    do_wr    = wr_vld & ~full;
    do_rd    = rd_vld & rd_rdy;
    wr_ptr_d = do_wr ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_rd ? rd_ptr_q + AW'(1) : rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_wr && !do_rd)      cnt_d = cnt_q + (AW+1)'(1);
    else if (!do_wr && do_rd) cnt_d = cnt_q - (AW+1)'(1);
    // Mask stale storage so the output reads zero whenever the queue is empty.
    rd_dat   = rd_vld ? mem_q[rd_ptr_q] : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_dat;
  end
endmodule

module hdmi_in_capture_v2 #(
  parameter int   CW          = 8,
  parameter int   CNT_W       = 12,
  parameter int   TS_W        = 24,
  parameter int   FIFO_DEPTH  = 16,
  parameter int   LOCK_FRAMES = 3,
  parameter logic HS_POL      = 1'b1,
  parameter logic VS_POL      = 1'b1
) (
  input  logic                          hdmi_in_clk,
  input  logic                          rst,
  input  logic [CW-1:0]                 pix_r,
  input  logic [CW-1:0]                 pix_g,
  input  logic [CW-1:0]                 pix_b,
  input  logic                          pix_de,
  input  logic                          pix_hs,
  input  logic                          pix_vs,
  input  logic [TS_W-1:0]               time_count,
  input  logic                          capture_en,
  output logic [3*CW+2*CNT_W+TS_W+1:0]  out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          locked,
  output logic [CNT_W-1:0]              meas_h_active,
  output logic [CNT_W-1:0]              meas_v_active,
  output logic [CNT_W-1:0]              frame_count,
  output logic                          overflow,
  input  logic                          overflow_clear,
  output logic [CNT_W-1:0]              drop_count
);
  localparam int OW = 3*CW+2*CNT_W+TS_W+2;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [3:0]       LOCK_M1 = 4'(LOCK_FRAMES-1);

  typedef enum logic {SEARCH, LOCKED} state_t;
  typedef struct packed {
    logic [CW-1:0]   r;
    logic [CW-1:0]   g;
    logic [CW-1:0]   b;
    logic            de;
    logic            hs;
    logic            vs;
    logic            cap;
    logic [TS_W-1:0] ts;
  } stage_t;

  stage_t           s0_q, s0_d, s1_q, s1_d;
  logic [CNT_W-1:0] x_q, x_d, y_q, y_d, len_ref_q, len_ref_d;
  logic [CNT_W-1:0] meas_h_q, meas_h_d, meas_v_q, meas_v_d;
  logic [CNT_W-1:0] prev_h_q, prev_h_d, prev_v_q, prev_v_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d, drop_cnt_q, drop_cnt_d;
  logic             line_err_q, line_err_d, gate_q, gate_d, ovf_q, ovf_d;
  logic [3:0]       match_q, match_d;
  state_t           state_q, state_d;
  logic             fs, eol, sof, line_err_now, clean, same, push, drop, fifo_full;
  logic [CNT_W-1:0] line_len;
  logic [OW-1:0]    wr_dat;
  logic             unused_bits;

  always_comb begin
    s0_d = '{r: pix_r, g: pix_g, b: pix_b, de: pix_de, hs: (pix_hs == HS_POL),
             vs: (pix_vs == VS_POL), cap: capture_en, ts: time_count};
    s1_d = s0_q;

    fs           = s0_q.vs & ~s1_q.vs;
    eol          = s1_q.de & ~s0_q.de;
    sof          = (x_q == '0) && (y_q == '0);
    line_len     = x_q + CNT_ONE;
    line_err_now = eol && (y_q != '0) && (line_len != len_ref_q);

    x_d = '0;
    if (s1_q.de && !eol) x_d = (x_q == CNT_MAX) ? x_q : x_q + CNT_ONE;
    y_d        = y_q;
    len_ref_d  = len_ref_q;
    line_err_d = line_err_q;
    if (fs) begin
      y_d        = '0;
      len_ref_d  = '0;
      line_err_d = 1'b0;
    end else begin
      if (eol && y_q != CNT_MAX) y_d = y_q + CNT_ONE;
      if (eol && y_q == '0)      len_ref_d = line_len;
      if (line_err_now)          line_err_d = 1'b1;
    end

    // A frame that is not clean also clears the reference, so relock restarts from scratch.
    clean       = !line_err_q && (len_ref_q != '0) && (y_q != '0);
    same        = (len_ref_q == prev_h_q) && (y_q == prev_v_q);
    meas_h_d    = fs ? len_ref_q : meas_h_q;
    meas_v_d    = fs ? y_q : meas_v_q;
    prev_h_d    = prev_h_q;
    prev_v_d    = prev_v_q;
    frame_cnt_d = fs ? frame_cnt_q + CNT_ONE : frame_cnt_q;
    if (fs) begin
      prev_h_d = clean ? len_ref_q : '0;
      prev_v_d = clean ? y_q : '0;
    end

    state_d = state_q;
    match_d = match_q;
    gate_d  = gate_q;
    if (fs) begin
      if (state_q == SEARCH) begin
        match_d = (clean && same) ? match_q + 4'd1 : 4'd0;
        if (clean && match_d >= LOCK_M1) begin
          state_d = LOCKED;
          match_d = 4'd0;
        end
      end else if (!(clean && same)) begin
        state_d = SEARCH;
        match_d = 4'd0;
      end
      gate_d = (state_d == LOCKED) && s0_q.cap;
    end else if (state_q == LOCKED && line_err_now) begin
      state_d = SEARCH;
      match_d = 4'd0;
      gate_d  = 1'b0;
    end

    push   = s1_q.de & gate_q;
    drop   = push & fifo_full;
    wr_dat = {sof, eol, s1_q.r, s1_q.g, s1_q.b, x_q, y_q, s1_q.ts};
    ovf_d      = overflow_clear ? 1'b0 : (ovf_q | drop);
    drop_cnt_d = drop_cnt_q;
    if (overflow_clear)                   drop_cnt_d = '0;
    else if (drop && drop_cnt_q != CNT_MAX) drop_cnt_d = drop_cnt_q + CNT_ONE;
  end

  always_ff @(posedge hdmi_in_clk or posedge rst) begin
    if (rst) begin
      s0_q        <= '0;
      s1_q        <= '0;
      x_q         <= '0;
      y_q         <= '0;
      len_ref_q   <= '0;
      line_err_q  <= 1'b0;
      meas_h_q    <= '0;
      meas_v_q    <= '0;
      prev_h_q    <= '0;
      prev_v_q    <= '0;
      frame_cnt_q <= '0;
      state_q     <= SEARCH;
      match_q     <= 4'd0;
      gate_q      <= 1'b0;
      ovf_q       <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      s0_q        <= s0_d;
      s1_q        <= s1_d;
      x_q         <= x_d;
      y_q         <= y_d;
      len_ref_q   <= len_ref_d;
      line_err_q  <= line_err_d;
      meas_h_q    <= meas_h_d;
      meas_v_q    <= meas_v_d;
      prev_h_q    <= prev_h_d;
      prev_v_q    <= prev_v_d;
      frame_cnt_q <= frame_cnt_d;
      state_q     <= state_d;
      match_q     <= match_d;
      gate_q      <= gate_d;
      ovf_q       <= ovf_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  sync_fifo #(.W(OW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (hdmi_in_clk),
    .rst    (rst),
    .wr_vld (push),
    .wr_dat (wr_dat),
    .full   (fifo_full),
    .rd_vld (out_valid),
    .rd_rdy (out_ready),
    .rd_dat (out_data)
  );

  assign locked        = (state_q == LOCKED);
  assign meas_h_active = meas_h_q;
  assign meas_v_active = meas_v_q;
  assign frame_count   = frame_cnt_q;
  assign overflow      = ovf_q;
  assign drop_count    = drop_cnt_q;
  assign unused_bits   = ^{s1_q.hs, s1_q.cap};
endmodule

// File: tb/tb_hdmi_in_capture_v2.sv
// Directed bench for hdmi_in_capture_v2: 8x4 frames, lock/unlock, overflow, capture gating, latency, reset.
module tb_hdmi_in_capture_v2;
  logic        hdmi_in_clk;
  logic        rst;
  logic [7:0]  pix_r, pix_g, pix_b;
  logic        pix_de, pix_hs, pix_vs;
  logic [23:0] time_count;
  logic        capture_en;
  logic [73:0] out_data;
  logic        out_valid, out_ready, locked;
  logic [11:0] meas_h_active, meas_v_active, frame_count, drop_count;
  logic        overflow, overflow_clear;

  typedef struct packed {
    logic        sof;
    logic        eol;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
    logic [11:0] x;
    logic [11:0] y;
    logic [23:0] ts;
  } word_t;

  word_t rx[$];
  int    n_checks = 0;
  int    n_errors = 0;
  int    tc = 0;
  int    t0;
  logic  lock_at_eol [4];

  hdmi_in_capture_v2 dut (
    .hdmi_in_clk(hdmi_in_clk), .rst(rst), .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .pix_de(pix_de), .pix_hs(pix_hs), .pix_vs(pix_vs), .time_count(time_count),
    .capture_en(capture_en), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .locked(locked), .meas_h_active(meas_h_active), .meas_v_active(meas_v_active),
    .frame_count(frame_count), .overflow(overflow), .overflow_clear(overflow_clear),
    .drop_count(drop_count)
  );

  initial begin
    hdmi_in_clk = 1'b0;
    forever #5 hdmi_in_clk = ~hdmi_in_clk;
  end

  always @(negedge hdmi_in_clk)
    if (!rst && out_valid && out_ready) rx.push_back(out_data);

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge hdmi_in_clk);
    #1;
    tc++;
    time_count = 24'(tc);
  endtask

  function automatic word_t exp_word(input int k, input int fid, input int ts0);
    word_t w;
    int x, y;
    x = k % 8;
    y = k / 8;
    w.sof = (k == 0);
    w.eol = (x == 7);
    w.r   = 8'(x);
    w.g   = 8'(y);
    w.b   = 8'(fid);
    w.x   = 12'(x);
    w.y   = 12'(y);
    w.ts  = 24'(ts0 + y * 11 + x);
    return w;
  endfunction

  // VS for 2 cycles, 2 blank, 4 lines of 8 DE pixels + 3 blank, 4 idle.
  task automatic send_frame(input int fid, input int short_line, input int cap_line, output int ts0);
    ts0 = 0;
    pix_de = 1'b0;
    pix_vs = 1'b1;
    repeat (2) tick();
    pix_vs = 1'b0;
    repeat (2) tick();
    for (int l = 0; l < 4; l++) begin
      if (l == cap_line) capture_en = 1'b1;
      for (int x = 0; x < ((l == short_line) ? 7 : 8); x++) begin
        pix_de = 1'b1;
        pix_r  = 8'(x);
        pix_g  = 8'(l);
        pix_b  = 8'(fid);
        if (l == 0 && x == 0) ts0 = tc;
        tick();
      end
      pix_de = 1'b0;
      repeat (3) tick();
      lock_at_eol[l] = locked;
    end
    repeat (4) tick();
  endtask

  task automatic verify_frame(input string tag, input int fid, input int nexp, input int ts0);
    check({tag, "_count"}, 80'(rx.size()), 80'(nexp));
    for (int k = 0; k < nexp && k < rx.size(); k++)
      check({tag, "_word"}, 80'(rx[k]), 80'(exp_word(k, fid, ts0)));
    rx.delete();
  endtask

  initial begin
    int n_y3, n_lo, tn;
    word_t w;
    rst = 1'b1;
    pix_r = '0; pix_g = '0; pix_b = '0;
    pix_de = 1'b0; pix_hs = 1'b0; pix_vs = 1'b0;
    time_count = '0; capture_en = 1'b0; out_ready = 1'b0; overflow_clear = 1'b0;
    repeat (3) tick();
    check("rst_locked", 80'(locked), 80'(0));
    check("rst_valid", 80'(out_valid), 80'(0));
    check("rst_data", 80'(out_data), 80'(0));
    check("rst_frame_count", 80'(frame_count), 80'(0));
    check("rst_meas_h", 80'(meas_h_active), 80'(0));
    check("rst_meas_v", 80'(meas_v_active), 80'(0));
    check("rst_overflow", 80'(overflow), 80'(0));
    check("rst_drop_count", 80'(drop_count), 80'(0));
    rst = 1'b0;
    out_ready = 1'b1;
    capture_en = 1'b1;
    tick();

    for (int f = 1; f <= 3; f++) send_frame(f, -1, -1, t0);
    check("no_lock_after_f3", 80'(locked), 80'(0));
    check("no_words_pre_lock", 80'(rx.size()), 80'(0));
    send_frame(4, -1, -1, t0);
    check("locked_f4", 80'(locked), 80'(1));
    check("meas_h", 80'(meas_h_active), 80'(8));
    check("meas_v", 80'(meas_v_active), 80'(4));
    check("frame_count_f4", 80'(frame_count), 80'(4));
    verify_frame("f4", 4, 32, t0);

    send_frame(5, 2, -1, t0);
    check("lock_held_line1", 80'(lock_at_eol[1]), 80'(1));
    check("lock_lost_line2", 80'(lock_at_eol[2]), 80'(0));
    n_y3 = 0;
    n_lo = 0;
    foreach (rx[i]) begin
      if (rx[i].y == 12'd3) n_y3++;
      if (rx[i].y < 12'd2) n_lo++;
    end
    check("err_frame_no_line3", 80'(n_y3), 80'(0));
    check("err_frame_lines01", 80'(n_lo), 80'(16));
    rx.delete();

    for (int f = 6; f <= 8; f++) send_frame(f, -1, -1, t0);
    check("no_relock_after_f8", 80'(locked), 80'(0));
    check("no_words_relock", 80'(rx.size()), 80'(0));
    rx.delete();
    send_frame(9, -1, -1, t0);
    check("relocked_f9", 80'(locked), 80'(1));
    verify_frame("f9", 9, 32, t0);

    out_ready = 1'b0;
    send_frame(10, -1, -1, t0);
    check("ovf_set", 80'(overflow), 80'(1));
    check("ovf_drop_count", 80'(drop_count), 80'(16));
    check("ovf_valid", 80'(out_valid), 80'(1));
    overflow_clear = 1'b1;
    tick();
    overflow_clear = 1'b0;
    check("ovf_cleared", 80'(overflow), 80'(0));
    check("drop_cleared", 80'(drop_count), 80'(0));
    out_ready = 1'b1;
    repeat (20) tick();
    verify_frame("f10", 10, 16, t0);

    capture_en = 1'b0;
    send_frame(11, -1, 1, t0);
    check("midframe_en_no_words", 80'(rx.size()), 80'(0));
    rx.delete();
    send_frame(12, -1, -1, t0);
    verify_frame("f12", 12, 32, t0);

    // Single-pixel latency inside locked frame 13.
    out_ready = 1'b0;
    pix_vs = 1'b1;
    repeat (2) tick();
    pix_vs = 1'b0;
    repeat (2) tick();
    pix_de = 1'b1; pix_r = 8'd0; pix_g = 8'd0; pix_b = 8'd13;
    tn = tc;
    tick();
    pix_de = 1'b0;
    check("lat_edgeN", 80'(out_valid), 80'(0));
    tick();
    check("lat_edgeN1", 80'(out_valid), 80'(0));
    tick();
    check("lat_edgeN2", 80'(out_valid), 80'(1));
    repeat (3) tick();
    check("lat_hold", 80'(out_valid), 80'(1));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("lat_pop", 80'(out_valid), 80'(0));
    w = '{sof: 1'b1, eol: 1'b1, r: 8'd0, g: 8'd0, b: 8'd13, x: 12'd0, y: 12'd0, ts: 24'(tn)};
    check("lat_count", 80'(rx.size()), 80'(1));
    if (rx.size() > 0) check("lat_word", 80'(rx[0]), 80'(w));
    rx.delete();

    // Asynchronous reset mid-frame while locked.
    pix_de = 1'b1;
    tick();
    pix_de = 1'b0;
    repeat (3) tick();
    check("pre_rst_valid", 80'(out_valid), 80'(1));
    check("pre_rst_locked", 80'(locked), 80'(1));
    check("pre_rst_frame_count", 80'(frame_count), 80'(13));
    @(posedge hdmi_in_clk);
    #3;
    rst = 1'b1;
    #1;
    check("arst_locked", 80'(locked), 80'(0));
    check("arst_valid", 80'(out_valid), 80'(0));
    check("arst_frame_count", 80'(frame_count), 80'(0));
    repeat (2) tick();
    rst = 1'b0;
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
